// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and default timing for the SPI master transmitter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_BYTE_W   = 8;
    localparam int HP_CNT_W     = 8;
    localparam int TMR_W        = 16;

    localparam int HALF_PER_DEF = 50;
    localparam int CS_SETUP_DEF = 4;
    localparam int CS_HOLD_DEF  = 4;
    localparam int CS_GAP_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ============================================================================
//  Module   : spi_sck_gen
//  Purpose  : Mode-0 SCK generator; strobes flag the cycle before each edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int HALF_PER = HALF_PER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [HP_CNT_W-1:0] c_last = HP_CNT_W'(HALF_PER - 1);

    logic [HP_CNT_W-1:0] r_cnt;
    logic                r_sck;
    logic                w_wrap;

    assign w_wrap = en && (r_cnt == c_last);

    // Disabling parks the generator low with a fresh count, so every byte
    // starts with a full low half-period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + HP_CNT_W'(1);
        end
    end

    assign sck      = r_sck;
    assign rise_stb = w_wrap && !r_sck;
    assign fall_stb = w_wrap &&  r_sck;

endmodule

`default_nettype wire

// File: rtl/spi_master_tx.sv
// ============================================================================
//  Module   : spi_master_tx
//  Purpose  : Byte-oriented mode-0 SPI master with valid/ready byte source.
//             Define SPI_LSB_FIRST_EN for LSB-first in both directions.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master_tx
    import spi_pkg::*;
#(
    parameter int HALF_PER = HALF_PER_DEF,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF,
    parameter int CS_GAP   = CS_GAP_DEF
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n
);

    localparam logic [TMR_W-1:0] c_setup_last = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] c_hold_last  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] c_gap_last   = TMR_W'(CS_GAP - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TMR_W-1:0]        r_tmr;
    logic [2:0]              r_bit_cnt;
    logic                    r_done;
    logic                    r_last;
    logic [SPI_BYTE_W-1:0]   r_tx_shift;
    logic [SPI_BYTE_W-1:0]   r_rx_shift;
    logic [SPI_BYTE_W-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_cs_n;
    logic                    r_miso_meta;
    logic                    r_miso_sync;

    logic                    w_tx_ready;
    logic                    w_accept;
    logic                    w_sck_en;
    logic                    w_sck;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_mosi;
    logic [SPI_BYTE_W-1:0]   w_tx_next;
    logic [SPI_BYTE_W-1:0]   w_rx_next;

`ifdef SPI_LSB_FIRST_EN
    assign w_mosi    = r_tx_shift[0];
    assign w_tx_next = {1'b0, r_tx_shift[SPI_BYTE_W-1:1]};
    assign w_rx_next = {r_miso_sync, r_rx_shift[SPI_BYTE_W-1:1]};
`else
    assign w_mosi    = r_tx_shift[SPI_BYTE_W-1];
    assign w_tx_next = {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
    assign w_rx_next = {r_rx_shift[SPI_BYTE_W-2:0], r_miso_sync};
`endif

    assign w_tx_ready = !reset && ((r_state == ST_IDLE) || (r_state == ST_WAIT));
    assign w_accept   = tx_valid && w_tx_ready;
    // r_done holds SCK off for the rx_valid cycle that separates bytes
    assign w_sck_en   = (r_state == ST_SHIFT) && !r_done;

    spi_sck_gen #(
        .HALF_PER (HALF_PER)
    ) u_sck_gen (
        .clk      (sys_clock),
        .rst      (reset),
        .en       (w_sck_en),
        .sck      (w_sck),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)               w_state_nxt = ST_SETUP;
            ST_SETUP: if (r_tmr == c_setup_last)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_done)                 w_state_nxt = r_last ? ST_HOLD : ST_WAIT;
            ST_WAIT:  if (w_accept)               w_state_nxt = ST_SHIFT;
            ST_HOLD:  if (r_tmr >= c_hold_last)   w_state_nxt = ST_GAP;
            ST_GAP:   if (r_tmr == c_gap_last)    w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_tmr       <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_cs_n      <= 1'b1;
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= spi_miso;
            r_miso_sync <= r_miso_meta;
            r_rx_valid  <= 1'b0;

            // The post-byte cycle in SHIFT counts as the first hold cycle.
            if (w_state_nxt != r_state) begin
                r_tmr <= (w_state_nxt == ST_HOLD) ? TMR_W'(1) : '0;
            end else begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_accept) begin
                r_tx_shift <= tx_data;
                r_last     <= tx_last;
                r_bit_cnt  <= '0;
                r_done     <= 1'b0;
                r_cs_n     <= 1'b0;
            end

            if (w_rise) begin
                r_rx_shift <= w_rx_next;
            end

            if (w_fall) begin
                r_tx_shift <= w_tx_next;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_done     <= 1'b1;
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end

            if ((r_state == ST_HOLD) && (w_state_nxt == ST_GAP)) begin
                r_cs_n <= 1'b1;
            end
        end
    end

    assign tx_ready = w_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != ST_IDLE);
    assign spi_sck  = w_sck;
    assign spi_mosi = w_mosi;
    assign spi_cs_n = r_cs_n;

endmodule

`default_nettype wire
